// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the 64-bit register-file writeback port between
// the ALU path (requester 0) and the load unit (requester 1), with a one-entry output slot.

module mux2_64 (
    input  logic        sel,
    input  logic [63:0] in0,
    input  logic [63:0] in1,
    output logic [63:0] out
);
    assign out = sel ? in1 : in0;
endmodule

module wb_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [REG_W-1:0]  req0_rd,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [REG_W-1:0]  req1_rd,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_src,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [REG_W-1:0]  out_rd_r;
    logic              out_src_r;
    logic              pri_r;
    logic [CNT_W-1:0]  conflict_cnt_r;

    logic              slot_free_s;
    logic              grant_valid_s;
    logic              grant_s;
    logic [DATA_W-1:0] win_data_s;
    logic [REG_W-1:0]  win_rd_s;
    logic              contention_s;

    assign slot_free_s = !out_valid_r || out_ready;

    // Grant selection: pointer breaks ties, a lone requester always wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        if (!slot_free_s) begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end else if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = pri_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end
    end

    assign req0_ready = grant_valid_s && (grant_s == 1'b0);
    assign req1_ready = grant_valid_s && (grant_s == 1'b1);

    mux2_64 u_data_mux (
        .sel (grant_s),
        .in0 (req0_data),
        .in1 (req1_data),
        .out (win_data_s)
    );

    assign win_rd_s = grant_s ? req1_rd : req0_rd;

    // Both valid means at least one is refused, since only one ready can be high.
    assign contention_s = req0_valid && req1_valid && !(req0_ready && req1_ready);

    // Output slot and priority pointer; writes to x0 are acknowledged but dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_rd_r    <= {REG_W{1'b0}};
            out_src_r   <= 1'b0;
            pri_r       <= 1'b0;
        end else if (slot_free_s) begin
            if (grant_valid_s) begin
                pri_r <= ~grant_s;
                if (win_rd_s != {REG_W{1'b0}}) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= win_data_s;
                    out_rd_r    <= win_rd_s;
                    out_src_r   <= grant_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Saturating contention counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else if (contention_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_rd       = out_rd_r;
    assign out_src      = out_src_r;
    assign conflict_cnt = conflict_cnt_r;
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single 64-bit register-file writeback path between two result producers: requester 0 is the ALU/execute path, requester 1 is the load/long-latency unit. It picks one requester per cycle, steers its data through a mux2_64 instance driven by the grant, and registers the winner into a one-entry output slot with a valid/ready handshake toward the register-file write port. It sits between the MEM/WB stage producers and the register file.

## Interface
- DATA_W, 64, writeback data width; the mux2_64 datapath fixes it at 64.
- REG_W, 5, destination register index width.
- CNT_W, 16, width of the conflict counter.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req0_valid  input  1  requester 0 has a result.
- req0_data  input  DATA_W  requester 0 result.
- req0_rd  input  REG_W  requester 0 destination register.
- req0_ready  output  1  requester 0 result accepted this cycle (combinational).
- req1_valid, req1_data, req1_rd, req1_ready: same as requester 0, for requester 1.
- out_valid  output  1  output slot holds a write.
- out_data  output  DATA_W  registered write data.
- out_rd  output  REG_W  registered destination register.
- out_src  output  1  requester that produced the slot contents.
- out_ready  input  1  register-file port consumes the slot this cycle.
- conflict_cnt  output  CNT_W  saturating count of cycles where both requesters were valid and one was refused.

## Operation
- slot_free = !out_valid || out_ready.
- Grant, combinational, only when slot_free:
  - both requesters valid: grant goes to the priority pointer `pri`.
  - one requester valid: grant goes to that requester.
  - neither valid: no grant.
- reqN_ready = slot_free && grant==N. At most one ready is high per cycle. A requester holds valid, data and rd stable until it sees ready.
- On an accepted request (edge):
  - Data passes through the internal mux2_64, select = grant (0 picks req0_data).
  - out_data, out_rd and out_src load the winner's data, rd and index.
  - pri becomes the other requester.
- x0 discard: an accepted request with rd==0 is acknowledged, but out_valid loads 0. out_data, out_rd and out_src are not updated, and pri still toggles.
- slot_free with no grant: out_valid loads 0 and the data registers hold.
- !slot_free: all slot registers and pri hold, and both readies are 0.
- conflict_cnt increments when both requesters are valid and at least one ready is 0. This includes the case where both are refused because the slot is full. The counter saturates at 2^CNT_W−1 and clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_rd=0, out_src=0, pri=0, conflict_cnt=0.
  - Readies follow the grant rules immediately after reset, because the slot is free.
- Latency:
  - An accepted request appears at out_valid/out_data one cycle after the accepting edge.
  - With out_ready held high, the block sustains 1 write per cycle.
  - Under contention it alternates 0,1,0,1…
- Simultaneous pop and push: if out_valid && out_ready and a request is valid in the same cycle, the new write replaces the old one with no bubble.
- Backpressure: while out_valid && !out_ready, the slot contents are stable every cycle.
- Reset mid-transfer: the slot is dropped (out_valid→0 asynchronously). A requester that was being stalled re-arbitrates with pri=0.

## Test plan
- Reset, then req0 alone valid (data 0x1111_2222_3333_4444, rd=5), out_ready=1 -> req0_ready=1 in the same cycle; next cycle out_valid=1, out_data=0x1111_2222_3333_4444, out_rd=5, out_src=0.
- Both requesters valid continuously, out_ready=1, from reset -> grants go 0,1,0,1; conflict_cnt increments by 1 per cycle; out_src alternates starting at 0.
- Slot full with out_ready=0 for 3 cycles while req1 is valid -> req1_ready=0 and out_* stable for all 3 cycles; req1 is accepted in the cycle out_ready rises, with no bubble.
- req1 valid with rd=0, then req0 valid with rd=3 -> req1_ready=1, out_valid stays 0, and pri toggles; the following req0 write appears with out_rd=3.
- Force conflict_cnt to 0xFFFE by running contention for that many cycles, then continue contention -> value reaches 0xFFFF and holds.
- Assert rst_n=0 mid-cycle while out_valid=1 -> out_valid drops to 0 immediately without waiting for clk; after release, the first grant under contention goes to req0.
